ctrl_pipe_unit: RTL and testbench

//  Next-generation decode/control for the ARM pipeline: decodes the ID instruction and carries the control

---
 rtl/ctrl_pipe_unit.sv | 204 ++++++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: decodes the ID instruction into a control bundle and carries
// it through registered EX, MEM and WB stages. Handles external stall, sticky
// branch flush and load-use hazard bubbles, and counts hazard stall cycles.
module ctrl_pipe_unit #(
  parameter int INSTR_W  = 32,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16,
  parameter int LU_EN    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  id_instr,
  input  logic                id_valid,
  input  logic                stall_in,
  input  logic                flush,
  output logic                hazard_stall,
  output logic                ex_valid,
  output logic                ex_s,
  output logic                ex_shift_imm,
  output logic                ex_b_instr,
  output logic                ex_b_l,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [3:0]          ex_cond,
  output logic                mem_valid,
  output logic                mem_enable,
  output logic                mem_rw,
  output logic                mem_load,
  output logic [1:0]          mem_size,
  output logic                wb_valid,
  output logic                wb_rf_enable,
  output logic                wb_load,
  output logic [3:0]          wb_rd,
  output logic [CNT_W-1:0]    hazard_count
);

  // Full control bundle; later stages simply ignore the EX-only fields.
  typedef struct packed {
    logic                valid;
    logic                s;
    logic                shift_imm;
    logic                b_instr;
    logic                b_l;
    logic [ALU_OP_W-1:0] alu;
    logic [3:0]          cond;
    logic                m_en;
    logic                rw;
    logic                load;
    logic [1:0]          size;
    logic                rf_en;
    logic [3:0]          rd;
  } ctrl_t;

  ctrl_t            dec_s;
  ctrl_t            ex_d, ex_q;
  ctrl_t            mem_d, mem_q;
  ctrl_t            wb_d, wb_q;
  logic             pend_d, pend_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [2:0]       cls_s;
  logic             src_match_s;
  logic             hazard_raw_s;
  logic             flush_eff_s;

  assign cls_s       = id_instr[27:25];
  assign flush_eff_s = flush | pend_q;

  // Combinational decode of the ID instruction; unsupported or invalid -> bubble.
  always_comb begin
    dec_s = '0;
    if (id_valid && (id_instr != '0)) begin
      case (cls_s)
        3'b000, 3'b001: begin
          dec_s.valid     = 1'b1;
          dec_s.cond      = id_instr[31:28];
          dec_s.s         = id_instr[20];
          dec_s.alu       = ALU_OP_W'(id_instr[24:21]);
          dec_s.rf_en     = 1'b1;
          dec_s.rd        = id_instr[15:12];
          dec_s.shift_imm = (cls_s == 3'b000) ? (id_instr[11:7] != 5'd0) : 1'b0;
        end
        3'b010, 3'b011: begin
          dec_s.valid     = 1'b1;
          dec_s.cond      = id_instr[31:28];
          dec_s.load      = id_instr[20];
          dec_s.size      = id_instr[22:21];
          dec_s.m_en      = 1'b1;
          dec_s.rw        = ~id_instr[20];
          dec_s.rf_en     = id_instr[20];
          dec_s.rd        = id_instr[15:12];
          dec_s.alu       = id_instr[23] ? ALU_OP_W'(4'b0100) : ALU_OP_W'(4'b0010);
          dec_s.shift_imm = (cls_s == 3'b010);
        end
        3'b101: begin
          dec_s.valid     = 1'b1;
          dec_s.cond      = id_instr[31:28];
          dec_s.b_instr   = 1'b1;
          dec_s.b_l       = id_instr[24];
          dec_s.rf_en     = id_instr[24];
          dec_s.rd        = id_instr[15:12];
          dec_s.alu       = id_instr[24] ? ALU_OP_W'(4'b0100) : ALU_OP_W'(4'b0010);
        end
        default: begin
          dec_s = '0;
        end
      endcase
    end else begin
      dec_s = '0;
    end
  end

  // Load-use detection: a load in EX whose rd feeds a source of the ID instruction.
  always_comb begin
    src_match_s  = 1'b0;
    hazard_raw_s = 1'b0;
    if (dec_s.valid && !dec_s.b_instr) begin
      if (id_instr[19:16] == ex_q.rd) begin
        src_match_s = 1'b1;
      end else if (((cls_s == 3'b000) || (cls_s == 3'b011)) && (id_instr[3:0] == ex_q.rd)) begin
        src_match_s = 1'b1;
      end else if (((cls_s == 3'b010) || (cls_s == 3'b011)) && !id_instr[20] &&
                   (id_instr[15:12] == ex_q.rd)) begin
        src_match_s = 1'b1;
      end else begin
        src_match_s = 1'b0;
      end
    end else begin
      src_match_s = 1'b0;
    end
    if (LU_EN != 0) begin
      hazard_raw_s = ex_q.valid & ex_q.load & src_match_s;
    end else begin
      hazard_raw_s = 1'b0;
    end
  end

  // A stall or an applying flush masks the hazard request.
  assign hazard_stall = hazard_raw_s & ~stall_in & ~flush_eff_s;

  // Next-state selection: stall > flush/pending > hazard > normal advance.
  always_comb begin
    ex_d   = ex_q;
    mem_d  = mem_q;
    wb_d   = wb_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (stall_in) begin
      pend_d = pend_q | flush;
    end else if (flush_eff_s) begin
      ex_d   = '0;
      mem_d  = ex_q;
      wb_d   = mem_q;
      pend_d = 1'b0;
    end else if (hazard_raw_s) begin
      ex_d  = '0;
      mem_d = ex_q;
      wb_d  = mem_q;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      ex_d  = dec_s;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  // Stage registers with synchronous reset to all-bubble state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_s         = ex_q.s;
  assign ex_shift_imm = ex_q.shift_imm;
  assign ex_b_instr   = ex_q.b_instr;
  assign ex_b_l       = ex_q.b_l;
  assign ex_alu_op    = ex_q.alu;
  assign ex_cond      = ex_q.cond;
  assign mem_valid    = mem_q.valid;
  assign mem_enable   = mem_q.m_en;
  assign mem_rw       = mem_q.rw;
  assign mem_load     = mem_q.load;
  assign mem_size     = mem_q.size;
  assign wb_valid     = wb_q.valid;
  assign wb_rf_enable = wb_q.rf_en;
  assign wb_load      = wb_q.load;
  assign wb_rd        = wb_q.rd;
  assign hazard_count = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit with hand-computed expectations.
module tb_ctrl_pipe_unit;
  logic        clk = 1'b0;
  logic        reset, id_valid, stall_in, flush;
  logic [31:0] id_instr;
  logic        hazard_stall, ex_valid, ex_s, ex_shift_imm, ex_b_instr, ex_b_l;
  logic [3:0]  ex_alu_op, ex_cond;
  logic        mem_valid, mem_enable, mem_rw, mem_load;
  logic [1:0]  mem_size;
  logic        wb_valid, wb_rf_enable, wb_load;
  logic [3:0]  wb_rd;
  logic [15:0] hazard_count;
  int          checks = 0;
  int          failures = 0;

  localparam logic [31:0] ADD_I  = 32'hE0812003; // ADD r2,r1,r3
  localparam logic [31:0] LDR_I  = 32'hE5901000; // LDR r1,[r0]
  localparam logic [31:0] STRB_I = 32'hE5C21000; // STRB r1,[r2]
  localparam logic [31:0] BL_I   = 32'hEB000004;

  ctrl_pipe_unit dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
    .stall_in(stall_in), .flush(flush), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_s(ex_s), .ex_shift_imm(ex_shift_imm),
    .ex_b_instr(ex_b_instr), .ex_b_l(ex_b_l), .ex_alu_op(ex_alu_op), .ex_cond(ex_cond),
    .mem_valid(mem_valid), .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_load(mem_load),
    .mem_size(mem_size), .wb_valid(wb_valid), .wb_rf_enable(wb_rf_enable),
    .wb_load(wb_load), .wb_rd(wb_rd), .hazard_count(hazard_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; stall_in = 1'b0; flush = 1'b0; id_instr = 32'h0;
    tick(); tick();
    reset = 1'b0;
    #1;
    // 1: reset state
    check_eq("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("rst_ex_alu", {28'd0, ex_alu_op}, 32'd0);
    check_eq("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
    check_eq("rst_hcount", {16'd0, hazard_count}, 32'd0);
    check_eq("rst_hstall", {31'd0, hazard_stall}, 32'd0);

    // 2: ADD flows to WB
    id_instr = ADD_I; id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check_eq("add_ex_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("add_ex_alu", {28'd0, ex_alu_op}, 32'd4);
    check_eq("add_ex_shimm", {31'd0, ex_shift_imm}, 32'd0);
    check_eq("add_ex_cond", {28'd0, ex_cond}, 32'hE);
    tick(); tick();
    check_eq("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("add_wb_rfen", {31'd0, wb_rf_enable}, 32'd1);
    check_eq("add_wb_rd", {28'd0, wb_rd}, 32'd2);

    // 3: LDR r1 then ADD using r1 -> one hazard bubble
    id_instr = LDR_I; id_valid = 1'b1;
    tick();
    id_instr = ADD_I;
    #1;
    check_eq("lu_hstall_on", {31'd0, hazard_stall}, 32'd1);
    tick();
    check_eq("lu_ex_bubble", {31'd0, ex_valid}, 32'd0);
    check_eq("lu_mem_load", {31'd0, mem_load}, 32'd1);
    check_eq("lu_hcount1", {16'd0, hazard_count}, 32'd1);
    check_eq("lu_hstall_off", {31'd0, hazard_stall}, 32'd0);
    tick();
    id_valid = 1'b0;
    check_eq("lu_add_ex", {31'd0, ex_valid}, 32'd1);
    check_eq("lu_add_alu", {28'd0, ex_alu_op}, 32'd4);
    check_eq("lu_hcount_hold", {16'd0, hazard_count}, 32'd1);

    // 4: flush during a 3-cycle stall is remembered
    id_instr = ADD_I; id_valid = 1'b1;
    tick();
    stall_in = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("st_ex_hold1", {31'd0, ex_valid}, 32'd1);
    tick();
    tick();
    check_eq("st_ex_hold3", {31'd0, ex_valid}, 32'd1);
    check_eq("st_alu_hold", {28'd0, ex_alu_op}, 32'd4);
    stall_in = 1'b0;
    #1;
    check_eq("st_hstall_mask", {31'd0, hazard_stall}, 32'd0);
    tick();
    check_eq("fl_ex_bubble", {31'd0, ex_valid}, 32'd0);
    check_eq("fl_mem_old_ex", {31'd0, mem_valid}, 32'd1);
    tick();
    check_eq("fl_pend_clear", {31'd0, ex_valid}, 32'd1);

    // 5: LDR r1 then STRB r1 (store data hazard), then STRB controls
    id_instr = LDR_I;
    tick();
    id_instr = STRB_I;
    #1;
    check_eq("st_data_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    check_eq("st_hcount2", {16'd0, hazard_count}, 32'd2);
    tick();
    id_valid = 1'b0;
    check_eq("strb_ex_valid", {31'd0, ex_valid}, 32'd1);
    tick();
    check_eq("strb_mem_en", {31'd0, mem_enable}, 32'd1);
    check_eq("strb_mem_rw", {31'd0, mem_rw}, 32'd1);
    check_eq("strb_mem_size", {30'd0, mem_size}, 32'd2);
    check_eq("strb_mem_load", {31'd0, mem_load}, 32'd0);
    tick();
    check_eq("strb_wb_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("strb_wb_rfen", {31'd0, wb_rf_enable}, 32'd0);

    // 6: BL decode, then mid-stream reset
    id_instr = BL_I; id_valid = 1'b1;
    tick();
    check_eq("bl_ex_b", {31'd0, ex_b_instr}, 32'd1);
    check_eq("bl_ex_bl", {31'd0, ex_b_l}, 32'd1);
    check_eq("bl_ex_alu", {28'd0, ex_alu_op}, 32'd4);
    tick();
    check_eq("bl_mem_valid", {31'd0, mem_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; id_valid = 1'b0;
    check_eq("mrst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("mrst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_eq("mrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("mrst_hcount", {16'd0, hazard_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
